// File: rtl/posit_mul_arbiter.sv
// Round-robin arbiter sharing one combinational posit multiplier between two requesters.
// Define POSIT_MUL_ARB_STATS_EN to add the a_count/b_count/stall_count statistics outputs.

module multiplier #(
  parameter int N  = 16,
  parameter int ES = 3
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] p
);

  localparam int MW = N - ES;
  localparam int FW = N - 1 - ES;
  localparam int PW = 2 * MW;
  localparam int VW = 2 + ES + (PW - 1) + N;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic               nar;
    logic signed [31:0] scale;
    logic [MW-1:0]      mant;
  } dec_t;

  // Split a posit into sign, scale (regime*2^ES + exponent) and 1.fraction mantissa.
  function automatic dec_t decode(input logic [N-1:0] v);
    dec_t       d;
    logic [N-2:0] rem;
    logic [N-2:0] sh;
    logic       r0;
    logic       run;
    int         m;
    int         k;
    d      = '0;
    d.zero = (v == '0);
    d.nar  = (v == NAR);
    d.sign = v[N-1];
    rem    = v[N-1] ? (~v[N-2:0] + 1'b1) : v[N-2:0];
    r0     = rem[N-2];
    m      = 0;
    run    = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (rem[i] == r0)) m = m + 1;
      else run = 1'b0;
    end
    k       = r0 ? (m - 1) : -m;
    sh      = rem << (m + 1);
    d.scale = k * (2 ** ES) + int'(sh[N-2 -: ES]);
    d.mant  = {1'b1, sh[FW-1:0]};
    return d;
  endfunction

  dec_t               dx;
  dec_t               dy;
  logic [PW-1:0]      prod;
  logic [PW-2:0]      frac;
  int                 sc;
  int                 k;
  int                 amt;
  logic [ES-1:0]      e;
  logic               r;
  logic signed [VW-1:0] v;
  logic [N-2:0]       body;
  logic               guard;
  logic               sticky;

  // Rebuild regime|exponent|fraction left-aligned, let an arithmetic shift
  // stretch the regime, then round to nearest even and saturate to min/maxpos.
  always_comb begin
    dx   = decode(x);
    dy   = decode(y);
    prod = {{MW{1'b0}}, dx.mant} * {{MW{1'b0}}, dy.mant};
    sc   = dx.scale + dy.scale;
    if (prod[PW-1]) begin
      sc   = sc + 1;
      frac = prod[PW-2:0];
    end else begin
      frac = {prod[PW-3:0], 1'b0};
    end
    k      = sc >>> ES;
    e      = sc[ES-1:0];
    r      = (k >= 0);
    amt    = r ? k : (-k - 1);
    v      = {r, ~r, e, frac, {N{1'b0}}};
    v      = v >>> amt;
    body   = v[VW-1 -: N-1];
    guard  = v[VW-N];
    sticky = |v[VW-N-1:0];
    body   = body + {{(N-2){1'b0}}, guard & (sticky | body[0])};
    if (k > N - 2) body = '1;
    else if (k < -(N - 2)) body = {{(N-2){1'b0}}, 1'b1};
    if (dx.nar || dy.nar) p = NAR;
    else if (dx.zero || dy.zero) p = '0;
    else if (dx.sign ^ dy.sign) p = -{1'b0, body};
    else p = {1'b0, body};
  end

endmodule

module posit_mul_arbiter #(
  parameter int N  = 16,
  parameter int ES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [N-1:0] a_x,
  input  logic [N-1:0] a_y,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [N-1:0] b_x,
  input  logic [N-1:0] b_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_posit,
  output logic         out_id
`ifdef POSIT_MUL_ARB_STATS_EN
  ,
  output logic [31:0]  a_count,
  output logic [31:0]  b_count,
  output logic [31:0]  stall_count
`endif
);

  logic         s1_valid;
  logic [N-1:0] s1_x;
  logic [N-1:0] s1_y;
  logic         s1_id;
  logic         last_grant;
  logic [N-1:0] prod;
  logic         out_free;
  logic         s1_free;
  logic         grant_a;
  logic         grant_b;
  logic         a_fire;
  logic         b_fire;

  multiplier #(.N(N), .ES(ES)) u_mul (
    .x (s1_x),
    .y (s1_y),
    .p (prod)
  );

  // last_grant=1 means B was served last, so A wins the next tie.
  always_comb begin
    out_free = !out_valid || out_ready;
    s1_free  = !s1_valid || out_free;
    grant_a  = a_valid && (!b_valid || last_grant);
    grant_b  = b_valid && (!a_valid || !last_grant);
    a_ready  = s1_free && grant_a;
    b_ready  = s1_free && grant_b;
    a_fire   = a_valid && a_ready;
    b_fire   = b_valid && b_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_id      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (s1_free) begin
        s1_valid <= a_fire || b_fire;
        if (a_fire) begin
          s1_x  <= a_x;
          s1_y  <= a_y;
          s1_id <= 1'b0;
        end else if (b_fire) begin
          s1_x  <= b_x;
          s1_y  <= b_y;
          s1_id <= 1'b1;
        end
      end
      if (a_fire) last_grant <= 1'b0;
      else if (b_fire) last_grant <= 1'b1;
    end
  end

  // Output register: refills from stage 1 whenever it is empty or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= '0;
      out_id    <= 1'b0;
    end else if (out_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_posit <= prod;
        out_id    <= s1_id;
      end
    end
  end

`ifdef POSIT_MUL_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_count     <= '0;
      b_count     <= '0;
      stall_count <= '0;
    end else begin
      if (a_fire) a_count <= a_count + 32'd1;
      if (b_fire) b_count <= b_count + 32'd1;
      if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Directed self-checking bench for posit_mul_arbiter (stats outputs checked when
// POSIT_MUL_ARB_STATS_EN is defined).

module tb_posit_mul_arbiter;

  localparam int N  = 16;
  localparam int ES = 3;

  logic         clk;
  logic         rst;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_x;
  logic [N-1:0] a_y;
  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] b_x;
  logic [N-1:0] b_y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_posit;
  logic         out_id;
`ifdef POSIT_MUL_ARB_STATS_EN
  logic [31:0]  a_count;
  logic [31:0]  b_count;
  logic [31:0]  stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  posit_mul_arbiter #(.N(N), .ES(ES)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_x        (a_x),
    .a_y        (a_y),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_x        (b_x),
    .b_y        (b_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_posit  (out_posit),
    .out_id     (out_id)
`ifdef POSIT_MUL_ARB_STATS_EN
    ,
    .a_count    (a_count),
    .b_count    (b_count),
    .stall_count(stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [N-1:0] ax, input logic [N-1:0] ay,
                               input logic bv, input logic [N-1:0] bx, input logic [N-1:0] by,
                               input logic ordy);
    a_valid   = av;
    a_x       = ax;
    a_y       = ay;
    b_valid   = bv;
    b_x       = bx;
    b_y       = by;
    out_ready = ordy;
  endtask

  // One isolated request through an empty pipeline with the consumer always ready.
  task automatic sendOne(input string tag, input logic id, input logic [N-1:0] x,
                         input logic [N-1:0] y, input logic [N-1:0] exp);
    if (id) applyStimulus(1'b0, '0, '0, 1'b1, x, y, 1'b1);
    else applyStimulus(1'b1, x, y, 1'b0, '0, '0, 1'b1);
    #1;
    checkOutput({tag, "_ready"}, id ? b_ready : a_ready, 1);
    tick;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput({tag, "_early"}, out_valid, 0);
    tick;
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_posit"}, out_posit, exp);
    checkOutput({tag, "_id"}, out_id, id);
    tick;
    checkOutput({tag, "_drain"}, out_valid, 0);
  endtask

  logic [N-1:0] rr_ax  [2] = '{16'h4200, 16'h4400};
  logic [N-1:0] rr_ay  [2] = '{16'h4200, 16'h4400};
  logic [N-1:0] rr_bx  [2] = '{16'h4800, 16'hC000};
  logic [N-1:0] rr_by  [2] = '{16'h4800, 16'h4200};
  logic [N-1:0] rr_exp [4] = '{16'h4480, 16'h5000, 16'h4800, 16'hBE00};
  logic         rr_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int ai;
    int bi;
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    tick;
    tick;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_posit", out_posit, 0);
    checkOutput("rst_out_id", out_id, 0);
`ifdef POSIT_MUL_ARB_STATS_EN
    checkOutput("rst_a_count", a_count, 0);
    checkOutput("rst_stall_count", stall_count, 0);
`endif
    rst = 1'b0;
    tick;

    // Contention: A wins the first tie after reset, then grants alternate.
    ai = 0;
    bi = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(ai < 2, rr_ax[ai % 2], rr_ay[ai % 2], bi < 2, rr_bx[bi % 2], rr_by[bi % 2], 1'b1);
      #1;
      checkOutput($sformatf("rr_a_ready%0d", c), a_ready, (c % 2) == 0);
      checkOutput($sformatf("rr_b_ready%0d", c), b_ready, (c % 2) == 1);
      if ((c % 2) == 0) ai++;
      else bi++;
      tick;
      if (c >= 1) begin
        checkOutput($sformatf("rr_valid%0d", c - 1), out_valid, 1);
        checkOutput($sformatf("rr_posit%0d", c - 1), out_posit, rr_exp[c - 1]);
        checkOutput($sformatf("rr_id%0d", c - 1), out_id, rr_id[c - 1]);
      end
    end

    // Three stalled cycles hold the third result, then the fourth follows.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("stall_valid%0d", s), out_valid, 1);
      checkOutput($sformatf("stall_posit%0d", s), out_posit, rr_exp[2]);
      checkOutput($sformatf("stall_id%0d", s), out_id, rr_id[2]);
      tick;
    end
    out_ready = 1'b1;
    tick;
    checkOutput("rr_valid3", out_valid, 1);
    checkOutput("rr_posit3", out_posit, rr_exp[3]);
    checkOutput("rr_id3", out_id, rr_id[3]);
    tick;
    checkOutput("rr_drain", out_valid, 0);
`ifdef POSIT_MUL_ARB_STATS_EN
    checkOutput("stats_a_count", a_count, 2);
    checkOutput("stats_b_count", b_count, 2);
    checkOutput("stats_stall_count", stall_count, 3);
`endif

    sendOne("single", 1'b0, 16'h4200, 16'h4200, 16'h4480);
    sendOne("sp_zero", 1'b1, 16'h0000, 16'h6AD5, 16'h0000);
    sendOne("sp_nar", 1'b1, 16'h8000, 16'hAD15, 16'h8000);
    sendOne("sp_zero_nar", 1'b0, 16'h8000, 16'h0000, 16'h8000);
    sendOne("regime", 1'b0, 16'h5000, 16'h5000, 16'h6000);
    sendOne("half", 1'b1, 16'h3C00, 16'h4400, 16'h4000);
    sendOne("maxpos", 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    sendOne("minpos", 1'b1, 16'h0001, 16'h0001, 16'h0001);
    sendOne("lsb", 1'b0, 16'h4001, 16'h4001, 16'h4002);

    // Backpressure: two requests fit (stage 1 + output), the third waits.
    applyStimulus(1'b1, 16'h4200, 16'h4200, 1'b0, '0, '0, 1'b0);
    #1;
    checkOutput("bp_ready0", a_ready, 1);
    tick;
    applyStimulus(1'b1, 16'h4400, 16'h4400, 1'b0, '0, '0, 1'b0);
    #1;
    checkOutput("bp_ready1", a_ready, 1);
    tick;
    applyStimulus(1'b1, 16'h4800, 16'h4800, 1'b0, '0, '0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      #1;
      checkOutput($sformatf("bp_blocked%0d", s), a_ready, 0);
      checkOutput($sformatf("bp_hold%0d", s), out_posit, 16'h4480);
      checkOutput($sformatf("bp_hold_valid%0d", s), out_valid, 1);
      tick;
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_ready2", a_ready, 1);
    tick;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("bp_out1", out_posit, 16'h4800);
    checkOutput("bp_out1_valid", out_valid, 1);
    tick;
    checkOutput("bp_out2", out_posit, 16'h5000);
    checkOutput("bp_out2_valid", out_valid, 1);
    tick;
    checkOutput("bp_drain", out_valid, 0);

    // Reset mid-flight: last grant was A, so only a reset makes A win the next tie.
    applyStimulus(1'b1, 16'h4400, 16'h4400, 1'b0, '0, '0, 1'b1);
    #1;
    checkOutput("mid_ready", a_ready, 1);
    tick;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    tick;
    checkOutput("mid_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_async_valid", out_valid, 0);
    checkOutput("mid_async_posit", out_posit, 0);
    tick;
    rst = 1'b0;
    tick;
    checkOutput("mid_no_stale", out_valid, 0);
    applyStimulus(1'b1, 16'h4200, 16'h4200, 1'b1, 16'hC000, 16'h4200, 1'b1);
    #1;
    checkOutput("mid_tie_a", a_ready, 1);
    checkOutput("mid_tie_b", b_ready, 0);
    tick;
    applyStimulus(1'b0, '0, '0, 1'b1, 16'hC000, 16'h4200, 1'b1);
    #1;
    checkOutput("mid_b_ready", b_ready, 1);
    tick;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("mid_out_a", out_posit, 16'h4480);
    checkOutput("mid_out_a_id", out_id, 0);
    tick;
    checkOutput("mid_out_b", out_posit, 16'hBE00);
    checkOutput("mid_out_b_id", out_id, 1);
    tick;
    checkOutput("mid_drain", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_mul_arbiter.md
Name: posit_mul_arbiter

Overview:
- Shares one combinational posit multiplier (`multiplier #(N,ES)`) between two requesters, A and B.
- Arbitration is round-robin. Each requester presents operands over a valid/ready handshake.
- Operands are registered into the multiplier, and the product is registered at the output with a requester ID. The output is fully backpressurable.
- Sits between the posit ALU front end and the shared arithmetic datapath.

Parameters:
- N, 16, posit word width in bits; passed to the multiplier.
- ES, 3, exponent field width; passed to the multiplier.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has operands.
- a_ready  out  1  requester A operands accepted this cycle.
- a_x  in  N  requester A operand x.
- a_y  in  N  requester A operand y.
- b_valid  in  1  requester B has operands.
- b_ready  out  1  requester B operands accepted this cycle.
- b_x  in  N  requester B operand x.
- b_y  in  N  requester B operand y.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_posit  out  N  product from the multiplier.
- out_id  out  1  0 = result belongs to A, 1 = result belongs to B.

Behaviour:
- Reset values: out_valid=0, out_posit=0, out_id=0; stage-1 valid=0, stage-1 operands=0; last_grant=1, so A wins the first tie.
- Stage 1 register holds s1_x, s1_y, s1_id, s1_valid. It feeds the multiplier combinationally.
- Output stage: out_posit/out_id/out_valid are captured from the multiplier result and s1_id.
- Advance conditions:
  - out_free = !out_valid | out_ready.
  - s1_free = !s1_valid | out_free.
  - Stage 1 moves to output when s1_valid & out_free.
- Grant:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant.
  - a_ready = s1_free & grant_A; b_ready = s1_free & grant_B. At most one ready is high per cycle.
  - ready is combinational from valid and state. A requester must hold x/y stable while valid & !ready.
- last_grant updates only on an accepted transfer (valid & ready). An idle or stalled cycle leaves it unchanged.
- Latency: accepted at edge k, out_valid high after edge k+1.
- Throughput: one result per cycle when out_ready is held high.
- Backpressure:
  - out_ready=0 with out_valid=1 holds out_posit/out_id stable.
  - Stage 1 fills, then both readys drop.
  - No result is dropped or duplicated.
- Out-of-order ownership: results are returned in acceptance order; out_id identifies ownership.
- Simultaneous accept and drain: a full output, out_ready=1 and a valid s1 all in one cycle move the pipeline by one slot. New operands may be accepted in the same cycle.
- Special values are handled by the multiplier: zero, NaR (1 followed by N-1 zeros), and 0·NaR → NaR. This block does not modify them.
- Reset asserted mid-operation clears all in-flight work immediately. Results in flight are lost, and out_valid drops asynchronously.

Optional Feature:
- Macro: POSIT_MUL_ARB_STATS_EN.
- Defined:
  - Adds outputs a_count [31:0] and b_count [31:0], which increment on every accepted A or B transfer respectively.
  - Adds stall_count [31:0], which increments each cycle out_valid & !out_ready.
  - All counters reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Single request: a_x=a_y=0x4200 (1.5) with out_ready=1 → a_ready=1 in the same cycle; after 2 edges out_valid=1, out_posit=0x4480 (2.25), out_id=0.
- Contention: a_valid=b_valid=1 for 4 cycles with distinct operands and out_ready=1 → grants alternate A,B,A,B; out_id sequence 0,1,0,1; each product is correct.
- Specials: B sends 0x0000·0x6AD5 → 0x0000; B sends 0x8000·0xAD15 → 0x8000; A sends 0x8000·0x0000 → 0x8000.
- Backpressure: stream 3 A requests with out_ready=0 → exactly 2 accepted, then a_ready=0 and out_posit held. Raise out_ready → results drain in order, and the third request is accepted.
- Reset mid-flight: accept one request, assert rst before the result drains → out_valid=0 and no stale result after reset. The next tie is granted to A.
- Stats (macro on): the contention scenario plus a 3-cycle stall → a_count=2, b_count=2, stall_count=3.
